// File: rtl/id_stage_piped.sv
// MIPS decode stage: control decode, register file with write-through bypass,
// BEQ/BNE/J resolution in ID, and the ID/EX pipeline register with bubble insertion.
module id_stage_piped #(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 10,
    parameter int REG_BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PC_WIDTH-1:0]   if_id_pc_plus4,
    input  logic [31:0]           if_id_instr,
    input  logic                  if_id_valid,
    input  logic                  wb_reg_write,
    input  logic [4:0]            wb_write_reg_addr,
    input  logic [DATA_WIDTH-1:0] wb_write_back_data,
    input  logic                  data_hazard,
    input  logic                  flush,
    output logic                  if_id_stall,
    output logic                  branch_taken,
    output logic [PC_WIDTH-1:0]   branch_address,
    output logic                  jump_taken,
    output logic [PC_WIDTH-1:0]   jump_address,
    output logic                  id_ex_valid,
    output logic [PC_WIDTH-1:0]   id_ex_pc_plus4,
    output logic [DATA_WIDTH-1:0] id_ex_reg1,
    output logic [DATA_WIDTH-1:0] id_ex_reg2,
    output logic [DATA_WIDTH-1:0] id_ex_imm,
    output logic [4:0]            id_ex_rs,
    output logic [4:0]            id_ex_rt,
    output logic [4:0]            id_ex_dest,
    output logic                  id_ex_mem_to_reg,
    output logic                  id_ex_mem_read,
    output logic                  id_ex_mem_write,
    output logic                  id_ex_alu_src,
    output logic                  id_ex_reg_write,
    output logic [1:0]            id_ex_alu_op
);

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       beq;
        logic       bne;
        logic       jump;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic                  valid;
        logic [PC_WIDTH-1:0]   pc_plus4;
        logic [DATA_WIDTH-1:0] reg1;
        logic [DATA_WIDTH-1:0] reg2;
        logic [DATA_WIDTH-1:0] imm;
        logic [4:0]            rs;
        logic [4:0]            rt;
        logic [4:0]            dest;
        logic                  mem_to_reg;
        logic                  mem_read;
        logic                  mem_write;
        logic                  alu_src;
        logic                  reg_write;
        logic [1:0]            alu_op;
    } id_ex_t;

    logic [5:0]            opcode;
    logic [4:0]            rs, rt, rd;
    ctrl_t                 ctl;
    logic [DATA_WIDTH-1:0] gpr [32];
    logic [DATA_WIDTH-1:0] rd1, rd2, imm_ext;
    logic                  bubble, eq;
    id_ex_t                id_ex_d, id_ex_q;

    assign opcode  = if_id_instr[31:26];
    assign rs      = if_id_instr[25:21];
    assign rt      = if_id_instr[20:16];
    assign rd      = if_id_instr[15:11];
    assign imm_ext = {{(DATA_WIDTH-16){if_id_instr[15]}}, if_id_instr[15:0]};

    always_comb begin
        ctl = '0;
        unique case (opcode)
            6'h00: begin ctl.reg_dst = 1'b1; ctl.reg_write = 1'b1; ctl.alu_op = 2'b10; end
            6'h23: begin
                ctl.alu_src = 1'b1; ctl.mem_to_reg = 1'b1;
                ctl.mem_read = 1'b1; ctl.reg_write = 1'b1;
            end
            6'h2B: begin ctl.alu_src = 1'b1; ctl.mem_write = 1'b1; end
            6'h08: begin ctl.alu_src = 1'b1; ctl.reg_write = 1'b1; end
            6'h04: begin ctl.beq = 1'b1; ctl.alu_op = 2'b01; end
            6'h05: begin ctl.bne = 1'b1; ctl.alu_op = 2'b01; end
            6'h02: ctl.jump = 1'b1;
            default: ctl = '0;
        endcase
    end

    // R0 is never written, so its storage stays at the reset value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) gpr[i] <= '0;
        end else if (wb_reg_write && wb_write_reg_addr != 5'd0) begin
            gpr[wb_write_reg_addr] <= wb_write_back_data;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [4:0] addr);
        if (addr == 5'd0)
            return '0;
        else if (REG_BYPASS != 0 && wb_reg_write && wb_write_reg_addr == addr)
            return wb_write_back_data;
        else
            return gpr[addr];
    endfunction

    assign rd1    = read_port(rs);
    assign rd2    = read_port(rt);
    assign eq     = (rd1 == rd2);
    assign bubble = data_hazard | flush | ~if_id_valid;

    assign if_id_stall    = data_hazard & if_id_valid;
    assign branch_taken   = ~bubble & ((ctl.beq & eq) | (ctl.bne & ~eq));
    assign jump_taken     = ~bubble & ctl.jump;
    assign branch_address = if_id_pc_plus4
                          + PC_WIDTH'({{PC_WIDTH{if_id_instr[15]}}, if_id_instr[15:0], 2'b00});
    assign jump_address   = PC_WIDTH'({if_id_instr[25:0], 2'b00});

    always_comb begin
        id_ex_d            = '0;
        id_ex_d.valid      = 1'b1;
        id_ex_d.pc_plus4   = if_id_pc_plus4;
        id_ex_d.reg1       = rd1;
        id_ex_d.reg2       = rd2;
        id_ex_d.imm        = imm_ext;
        id_ex_d.rs         = rs;
        id_ex_d.rt         = rt;
        id_ex_d.dest       = ctl.reg_dst ? rd : rt;
        id_ex_d.mem_to_reg = ctl.mem_to_reg;
        id_ex_d.mem_read   = ctl.mem_read;
        id_ex_d.mem_write  = ctl.mem_write;
        id_ex_d.alu_src    = ctl.alu_src;
        id_ex_d.reg_write  = ctl.reg_write;
        id_ex_d.alu_op     = ctl.alu_op;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      id_ex_q <= '0;
        else if (bubble) id_ex_q <= '0;
        else             id_ex_q <= id_ex_d;
    end

    assign id_ex_valid      = id_ex_q.valid;
    assign id_ex_pc_plus4   = id_ex_q.pc_plus4;
    assign id_ex_reg1       = id_ex_q.reg1;
    assign id_ex_reg2       = id_ex_q.reg2;
    assign id_ex_imm        = id_ex_q.imm;
    assign id_ex_rs         = id_ex_q.rs;
    assign id_ex_rt         = id_ex_q.rt;
    assign id_ex_dest       = id_ex_q.dest;
    assign id_ex_mem_to_reg = id_ex_q.mem_to_reg;
    assign id_ex_mem_read   = id_ex_q.mem_read;
    assign id_ex_mem_write  = id_ex_q.mem_write;
    assign id_ex_alu_src    = id_ex_q.alu_src;
    assign id_ex_reg_write  = id_ex_q.reg_write;
    assign id_ex_alu_op     = id_ex_q.alu_op;

endmodule

// File: tb/tb_id_stage_piped.sv
// Bench for id_stage_piped: directed scenarios plus random traffic against a
// register-array reference model; a REG_BYPASS=0 copy shares the same inputs.
module tb_id_stage_piped;

    typedef struct packed {
        logic        valid;
        logic [9:0]  pc;
        logic [31:0] r1, r2, imm;
        logic [4:0]  rs, rt, dest;
        logic        m2r, mr, mw, as, rw;
        logic [1:0]  op;
    } idex_t;

    logic        clk = 1'b0, reset = 1'b0;
    logic [9:0]  pc = '0;
    logic [31:0] instr = '0;
    logic        valid = 1'b0, wbw = 1'b0, dh = 1'b0, fl = 1'b0;
    logic [4:0]  wba = '0;
    logic [31:0] wbd = '0;

    logic        stall, bt, jt, v, m2r, mr, mw, as, rw;
    logic [9:0]  ba, ja, epc;
    logic [31:0] r1, r2, imm;
    logic [4:0]  ers, ert, edst;
    logic [1:0]  aop;
    logic        n_stall, n_bt, n_jt, n_v, n_m2r, n_mr, n_mw, n_as, n_rw;
    logic [9:0]  n_ba, n_ja, n_epc;
    logic [31:0] n_r1, n_r2, n_imm;
    logic [4:0]  n_rs, n_rt, n_dst;
    logic [1:0]  n_aop;

    logic [31:0] mregs [32];
    int vecs = 0, errs = 0;

    always #5 clk = ~clk;

    id_stage_piped #(.DATA_WIDTH(32), .PC_WIDTH(10), .REG_BYPASS(1)) dut (
        .clk(clk), .reset(reset), .if_id_pc_plus4(pc), .if_id_instr(instr), .if_id_valid(valid),
        .wb_reg_write(wbw), .wb_write_reg_addr(wba), .wb_write_back_data(wbd),
        .data_hazard(dh), .flush(fl), .if_id_stall(stall), .branch_taken(bt), .branch_address(ba),
        .jump_taken(jt), .jump_address(ja), .id_ex_valid(v), .id_ex_pc_plus4(epc),
        .id_ex_reg1(r1), .id_ex_reg2(r2), .id_ex_imm(imm), .id_ex_rs(ers), .id_ex_rt(ert),
        .id_ex_dest(edst), .id_ex_mem_to_reg(m2r), .id_ex_mem_read(mr), .id_ex_mem_write(mw),
        .id_ex_alu_src(as), .id_ex_reg_write(rw), .id_ex_alu_op(aop));

    id_stage_piped #(.DATA_WIDTH(32), .PC_WIDTH(10), .REG_BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .if_id_pc_plus4(pc), .if_id_instr(instr), .if_id_valid(valid),
        .wb_reg_write(wbw), .wb_write_reg_addr(wba), .wb_write_back_data(wbd),
        .data_hazard(dh), .flush(fl), .if_id_stall(n_stall), .branch_taken(n_bt), .branch_address(n_ba),
        .jump_taken(n_jt), .jump_address(n_ja), .id_ex_valid(n_v), .id_ex_pc_plus4(n_epc),
        .id_ex_reg1(n_r1), .id_ex_reg2(n_r2), .id_ex_imm(n_imm), .id_ex_rs(n_rs), .id_ex_rt(n_rt),
        .id_ex_dest(n_dst), .id_ex_mem_to_reg(n_m2r), .id_ex_mem_read(n_mr), .id_ex_mem_write(n_mw),
        .id_ex_alu_src(n_as), .id_ex_reg_write(n_rw), .id_ex_alu_op(n_aop));

    function automatic idex_t dut_idex();
        return '{v, epc, r1, r2, imm, ers, ert, edst, m2r, mr, mw, as, rw, aop};
    endfunction

    // Reference model: register array read with optional same-cycle forwarding
    function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
        if (a == 0) return 0;
        if (byp && wbw && wba == a) return wbd;
        return mregs[a];
    endfunction

    function automatic idex_t m_idex(input bit byp);
        idex_t e = '0;
        logic [5:0] opc = instr[31:26];
        if (!valid || dh || fl) return e;
        e.valid = 1; e.pc = pc;
        e.rs = instr[25:21]; e.rt = instr[20:16];
        e.r1 = m_read(e.rs, byp); e.r2 = m_read(e.rt, byp);
        e.imm = {{16{instr[15]}}, instr[15:0]};
        e.dest = (opc == 6'h00) ? instr[15:11] : instr[20:16];
        case (opc)
            6'h00: begin e.rw = 1; e.op = 2; end
            6'h23: begin e.as = 1; e.m2r = 1; e.mr = 1; e.rw = 1; end
            6'h2B: begin e.as = 1; e.mw = 1; end
            6'h08: begin e.as = 1; e.rw = 1; end
            6'h04, 6'h05: e.op = 1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset && wbw && wba != 0) mregs[wba] = wbd;
        #1;
    endtask

    task automatic idle();
        valid = 0; wbw = 0; dh = 0; fl = 0;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        idle(); wbw = 1; wba = a; wbd = d;
        tick();
        wbw = 0;
    endtask

    task automatic test_reset();
        idex_t z = '0;
        reset = 0; idle();
        for (int i = 0; i < 32; i++) mregs[i] = 0;
        // beq $0,$0 while in reset: zeroed GPRs compare equal
        instr = {6'h04, 5'd0, 5'd0, 16'd1}; pc = 10'h010; valid = 1;
        #7;
        vecs++; if (dut_idex() !== z) begin errs++; $display("FAIL reset_idex got %h exp %h", dut_idex(), z); end
        vecs++; if (bt !== 1'b1) begin errs++; $display("FAIL reset_comb_bt got %b exp 1", bt); end
        vecs++; if (ba !== 10'h014) begin errs++; $display("FAIL reset_comb_ba got %h exp 014", ba); end
        @(posedge clk); #1;
        vecs++; if (dut_idex() !== z) begin errs++; $display("FAIL reset_hold got %h exp %h", dut_idex(), z); end
        #2 reset = 1; idle();
        tick();
    endtask

    task automatic test_rtype();
        wb_write(1, 5); wb_write(2, 7);
        instr = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}; pc = 10'h020; valid = 1;
        tick();
        vecs++;
        if (!(v === 1 && r1 === 5 && r2 === 7 && edst === 3 && rw === 1 && aop === 2'b10 && epc === 10'h020))
        begin errs++; $display("FAIL rtype got v=%b r1=%0d r2=%0d dst=%0d rw=%b op=%b exp 1/5/7/3/1/10", v, r1, r2, edst, rw, aop); end
    endtask

    task automatic test_bypass();
        logic [31:0] old = mregs[4];
        idle();
        instr = {6'h00, 5'd4, 5'd0, 5'd5, 5'd0, 6'h20}; valid = 1;
        wbw = 1; wba = 4; wbd = 32'hA5;
        tick(); wbw = 0;
        vecs++; if (r1 !== 32'hA5) begin errs++; $display("FAIL bypass_on got %h exp a5", r1); end
        vecs++; if (n_r1 !== old) begin errs++; $display("FAIL bypass_off got %h exp %h", n_r1, old); end
        tick();
        vecs++; if (n_r1 !== 32'hA5) begin errs++; $display("FAIL bypass_stored got %h exp a5", n_r1); end
    endtask

    task automatic test_branch();
        wb_write(1, 9); wb_write(2, 9);
        instr = {6'h04, 5'd1, 5'd2, 16'd3}; pc = 10'h040; valid = 1;
        #1;
        vecs++; if (bt !== 1'b1) begin errs++; $display("FAIL beq_taken got %b exp 1", bt); end
        vecs++; if (ba !== 10'h04C) begin errs++; $display("FAIL beq_addr got %h exp 04c", ba); end
        instr[31:26] = 6'h05;
        #1;
        vecs++; if (bt !== 1'b0) begin errs++; $display("FAIL bne_taken got %b exp 0", bt); end
        instr = {6'h04, 5'd1, 5'd2, 16'hFFFE};
        #1;
        vecs++; if (ba !== 10'h038) begin errs++; $display("FAIL beq_neg_addr got %h exp 038", ba); end
        tick();
        vecs++; if (!(v === 1 && rw === 0 && mr === 0 && mw === 0 && aop === 2'b01))
        begin errs++; $display("FAIL beq_idex got v=%b rw=%b mr=%b mw=%b op=%b exp 1/0/0/0/01", v, rw, mr, mw, aop); end
    endtask

    task automatic test_hazard();
        idex_t z = '0;
        idle();
        instr = {6'h23, 5'd1, 5'd5, 16'h0010}; pc = 10'h050; valid = 1; dh = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL hazard_stall%0d got %b exp 1", i, stall); end
            tick();
            vecs++; if (dut_idex() !== z) begin errs++; $display("FAIL hazard_bubble%0d got %h exp 0", i, dut_idex()); end
        end
        dh = 0;
        #1;
        vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL hazard_release got %b exp 0", stall); end
        tick();
        vecs++;
        if (!(v === 1 && mr === 1 && m2r === 1 && as === 1 && rw === 1 && edst === 5 && imm === 32'h10 && r1 === 9))
        begin errs++; $display("FAIL hazard_load got v=%b mr=%b dst=%0d imm=%h r1=%0d exp 1/1/5/10/9", v, mr, edst, imm, r1); end
    endtask

    task automatic test_jump_flush();
        idle();
        instr = {6'h02, 26'h10}; pc = 10'h060; valid = 1; fl = 1;
        #1;
        vecs++; if (jt !== 1'b0) begin errs++; $display("FAIL jflush_taken got %b exp 0", jt); end
        tick();
        vecs++; if (v !== 1'b0) begin errs++; $display("FAIL jflush_valid got %b exp 0", v); end
        fl = 0;
        #1;
        vecs++; if (jt !== 1'b1 || ja !== 10'h040) begin errs++; $display("FAIL jump got jt=%b ja=%h exp 1/040", jt, ja); end
        tick();
        vecs++; if (!(v === 1 && rw === 0 && mw === 0 && mr === 0)) begin errs++; $display("FAIL jump_idex got v=%b rw=%b exp 1/0", v, rw); end
    endtask

    task automatic test_r0();
        wb_write(0, 32'hFFFF);
        instr = {6'h00, 5'd0, 5'd0, 5'd7, 5'd0, 6'h20}; valid = 1;
        wbw = 1; wba = 0; wbd = 32'hFFFF;
        tick(); wbw = 0;
        vecs++; if (r1 !== 0 || r2 !== 0) begin errs++; $display("FAIL r0_read got %h/%h exp 0/0", r1, r2); end
    endtask

    task automatic test_random();
        logic [5:0] ops [9] = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h05, 6'h02, 6'h3F, 6'h0D};
        idex_t e, en;
        logic [31:0] a, b;
        logic ok, ebt, ejt;
        for (int n = 0; n < 400; n++) begin
            instr = $urandom;
            instr[31:26] = ops[$urandom_range(0, 8)];
            instr[25:21] = 5'($urandom_range(0, 7));
            instr[20:16] = 5'($urandom_range(0, 7));
            pc = 10'($urandom);
            valid = ($urandom_range(0, 5) != 0);
            dh = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 5) == 0);
            wbw = $urandom_range(0, 1);
            wba = 5'($urandom_range(0, 7));
            wbd = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
            #1;
            a = m_read(instr[25:21], 1); b = m_read(instr[20:16], 1);
            ok = valid & ~dh & ~fl;
            ebt = ok & (((instr[31:26] == 6'h04) && a == b) || ((instr[31:26] == 6'h05) && a != b));
            ejt = ok & (instr[31:26] == 6'h02);
            vecs++;
            if ({bt, jt, stall} !== {ebt, ejt, valid & dh})
            begin errs++; $display("FAIL rand_ctl%0d got %b%b%b exp %b%b%b", n, bt, jt, stall, ebt, ejt, valid & dh); end
            vecs++;
            if (ba !== 10'(32'(pc) + ({{16{instr[15]}}, instr[15:0]} << 2)) || ja !== 10'({instr[25:0], 2'b00}))
            begin errs++; $display("FAIL rand_addr%0d got %h/%h instr %h pc %h", n, ba, ja, instr, pc); end
            e = m_idex(1); en = m_idex(0);
            tick();
            vecs++; if (dut_idex() !== e) begin errs++; $display("FAIL rand_idex%0d got %h exp %h", n, dut_idex(), e); end
            vecs++; if ({n_r1, n_r2} !== {en.r1, en.r2}) begin errs++; $display("FAIL rand_nb%0d got %h/%h exp %h/%h", n, n_r1, n_r2, en.r1, en.r2); end
        end
        idle();
    endtask

    task automatic test_reset_midstream();
        idex_t z = '0;
        wb_write(1, 32'h1234);
        instr = {6'h00, 5'd1, 5'd1, 5'd2, 5'd0, 6'h20}; valid = 1;
        tick();
        vecs++; if (v !== 1'b1 || r1 !== 32'h1234) begin errs++; $display("FAIL mid_preload got v=%b r1=%h exp 1/1234", v, r1); end
        #2 reset = 0;
        for (int i = 0; i < 32; i++) mregs[i] = 0;
        #1;
        vecs++; if (dut_idex() !== z) begin errs++; $display("FAIL mid_reset got %h exp 0", dut_idex()); end
        #1 reset = 1;
        tick();
        vecs++; if (v !== 1'b1 || r1 !== 0 || edst !== 2) begin errs++; $display("FAIL mid_release got v=%b r1=%h dst=%0d exp 1/0/2", v, r1, edst); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_bypass();
        test_branch();
        test_hazard();
        test_jump_flush();
        test_r0();
        test_random();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
